// File: rtl/fir_eq_pkg.sv
// Shared types and sizing for the equaliser FIR coefficient path.
// Optional check-word support elsewhere is selected by the COEF_CHECKSUM_EN macro.
package fir_eq_pkg;

  localparam int NTAPS = 16;
  localparam int CW    = 16;

  // idx must be able to reach NTAPS, which is the index of the check word
  localparam int IDXW  = $clog2(NTAPS + 1);
  localparam int AW    = $clog2(NTAPS);

  typedef logic signed [CW-1:0] coef_t;
  typedef coef_t coef_arr_t [NTAPS];

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } ld_state_e;

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient register pair.
// The shadow bank is filled one word at a time.
// The commit strobe copies the whole shadow bank into the active bank in a single edge.
module fir_coef_bank
  import fir_eq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  coef_t         data,
  input  logic          commit,
  output coef_arr_t     coef
);

  coef_arr_t shadow;

  // Shadow bank: written one tap at a time while a load is in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) shadow[i] <= '0;
    end else if (we) begin
      shadow[idx] <= data;
    end
  end

  // Active bank: copied from the shadow bank all at once, so the filter never sees a mixed set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
    end else if (commit) begin
      coef <= shadow;
    end
  end

endmodule

// File: rtl/fir_coef_loader.sv
// Writer side of the FIR coefficient interface.
// Takes a valid/ready coefficient stream (tap 0 first) into a shadow bank.
// Commits the full set atomically to the active coef bus.
// Define COEF_CHECKSUM_EN to expect a trailing check word (sum of taps, mod 2^CW).
module fir_coef_loader
  import fir_eq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [CW-1:0] s_data,
  input  logic          s_last,
  output coef_arr_t     coef,
  output logic          coef_upd,
  output logic          busy,
  output logic          err
);

`ifdef COEF_CHECKSUM_EN
  localparam int LAST_IDX = NTAPS;
`else
  localparam int LAST_IDX = NTAPS - 1;
`endif

  ld_state_e       state_q, state_d;
  logic [IDXW-1:0] idx_q;
  logic            err_q;
  logic            coef_upd_q;
  logic            accept;
  logic            at_last;
  logic            check_ok;
  logic            frame_err;
  logic            bank_we;
  logic            bank_commit;
  logic            start_ok;

  assign accept   = s_valid & s_ready;
  assign at_last  = (idx_q == IDXW'(LAST_IDX));
  assign bank_we  = accept && (idx_q < IDXW'(NTAPS));
  assign start_ok = (state_q == IDLE) && start;

`ifdef COEF_CHECKSUM_EN
  logic [CW-1:0] sum_q;

  // Running sum of the coefficient beats, compared against the trailing check word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (bank_we) begin
      sum_q <= sum_q + s_data;
    end
  end

  assign check_ok = !at_last || (s_data == sum_q);
`else
  assign check_ok = 1'b1;
`endif

  // Next-state and handshake decode; framing errors abort straight back to IDLE
  always_comb begin
    state_d     = state_q;
    s_ready     = 1'b0;
    bank_commit = 1'b0;
    frame_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (at_last && s_last && check_ok) begin
            state_d = COMMIT;
          end else if (at_last || s_last) begin
            frame_err = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      COMMIT: begin
        bank_commit = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, beat index, sticky error and the post-commit update pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      err_q      <= 1'b0;
      coef_upd_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      coef_upd_q <= bank_commit;
      if (start_ok) begin
        idx_q <= '0;
        err_q <= 1'b0;
      end else begin
        if (accept)    idx_q <= idx_q + IDXW'(1);
        if (frame_err) err_q <= 1'b1;
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign err      = err_q;
  assign coef_upd = coef_upd_q;

  fir_coef_bank u_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (bank_we),
    .idx    (idx_q[AW-1:0]),
    .data   (coef_t'(s_data)),
    .commit (bank_commit),
    .coef   (coef)
  );

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed self-checking bench for fir_coef_loader.
// With COEF_CHECKSUM_EN defined, loads carry a trailing check word and the check-word cases run.
module tb_fir_coef_loader;
  import fir_eq_pkg::*;

`ifdef COEF_CHECKSUM_EN
  localparam int NBEATS = NTAPS + 1;
`else
  localparam int NBEATS = NTAPS;
`endif

  logic            clk;
  logic            rst;
  logic            start;
  logic            sValid;
  logic            sReady;
  logic [CW-1:0]   sData;
  logic            sLast;
  coef_arr_t       coef;
  logic            coefUpd;
  logic            busy;
  logic            err;

  logic [CW-1:0]   txWords [NTAPS+1];
  logic [CW-1:0]   expCoef [NTAPS];
  int              vecCount;
  int              missCount;

  fir_coef_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .s_valid  (sValid),
    .s_ready  (sReady),
    .s_data   (sData),
    .s_last   (sLast),
    .coef     (coef),
    .coef_upd (coefUpd),
    .busy     (busy),
    .err      (err)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the stimulus
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCoefs(input string tag);
    for (int i = 0; i < NTAPS; i++)
      checkOutput($sformatf("%s coef[%0d]", tag, i), {16'h0, coef[i]}, {16'h0, expCoef[i]});
  endtask

  // One beat; optional idle gap first, then hold valid until the accept edge
  task automatic sendBeat(input logic [CW-1:0] d, input logic last, input int gap);
    int waitCycles;
    for (int g = 0; g < gap; g++) begin
      sValid = 1'b0;
      tick();
      checkOutput("gap s_ready", 32'(sReady), 32'd1);
    end
    sValid = 1'b1;
    sData  = d;
    sLast  = last;
    waitCycles = 0;
    while (!sReady && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    if (!sReady) checkOutput("s_ready timeout", 32'(sReady), 32'd1);
    tick();
    sValid = 1'b0;
    sLast  = 1'b0;
  endtask

  // Start pulse then nBeats beats of txWords; s_last on beat lastAt (-1 = never)
  task automatic applyStimulus(input int nBeats, input int lastAt, input bit gaps);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("load busy", 32'(busy), 32'd1);
    checkOutput("load err cleared", 32'(err), 32'd0);
    for (int b = 0; b < nBeats; b++)
      sendBeat(txWords[b], (b == lastAt), gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  // Called right after the last-beat accept edge of a good load
  task automatic expectCommit(input string tag);
    checkOutput({tag, " upd early"}, 32'(coefUpd), 32'd0);
    checkOutput({tag, " busy in commit"}, 32'(busy), 32'd1);
    tick();
    checkOutput({tag, " coef_upd"}, 32'(coefUpd), 32'd1);
    checkOutput({tag, " busy after"}, 32'(busy), 32'd0);
    checkOutput({tag, " err"}, 32'(err), 32'd0);
    checkCoefs(tag);
    tick();
    checkOutput({tag, " upd single"}, 32'(coefUpd), 32'd0);
  endtask

  // Called right after an aborting beat; coef must not move
  task automatic expectError(input string tag);
    checkOutput({tag, " err"}, 32'(err), 32'd1);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " upd"}, 32'(coefUpd), 32'd0);
    tick();
    checkOutput({tag, " upd later"}, 32'(coefUpd), 32'd0);
    checkCoefs(tag);
  endtask

  task automatic fillPlus();
    for (int i = 0; i < NTAPS; i++) txWords[i] = CW'(i + 1);
    txWords[NTAPS] = 16'd136;
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;
    rst    = 1'b0;
    start  = 1'b0;
    sValid = 1'b0;
    sData  = '0;
    sLast  = 1'b0;
    for (int i = 0; i < NTAPS; i++) expCoef[i] = '0;

    // Reset values
    repeat (3) tick();
    checkCoefs("reset");
    checkOutput("reset s_ready", 32'(sReady), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset coef_upd", 32'(coefUpd), 32'd0);
    rst = 1'b1;
    tick();

    // Clean load 1..16, continuous valid
    $display("[TB] clean load");
    fillPlus();
    applyStimulus(NBEATS, NBEATS - 1, 1'b0);
    for (int i = 0; i < NTAPS; i++) expCoef[i] = CW'(i + 1);
    expectCommit("clean");

    // Early s_last on beat 7
    $display("[TB] early last");
    applyStimulus(8, 7, 1'b0);
    expectError("early");

    // Negative coefficients with random valid gaps
    $display("[TB] gapped load");
    for (int i = 0; i < NTAPS; i++) txWords[i] = CW'(-i);
    txWords[NTAPS] = 16'hFF88;
    applyStimulus(NBEATS, NBEATS - 1, 1'b1);
    for (int i = 0; i < NTAPS; i++) expCoef[i] = CW'(-i);
    expectCommit("gapped");

    // Missing s_last on the final beat
    $display("[TB] missing last");
    fillPlus();
    applyStimulus(NBEATS, -1, 1'b0);
    expectError("nolast");

`ifdef COEF_CHECKSUM_EN
    // Bad check word keeps the previous set
    $display("[TB] bad check word");
    fillPlus();
    txWords[NTAPS] = 16'd137;
    applyStimulus(NBEATS, NBEATS - 1, 1'b0);
    expectError("badsum");
`endif

    // Reset in the middle of a load
    $display("[TB] reset mid-load");
    fillPlus();
    applyStimulus(8, -1, 1'b0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < NTAPS; i++) expCoef[i] = '0;
    checkCoefs("midrst");
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst s_ready", 32'(sReady), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Full load after the reset, good check word 136 where enabled
    $display("[TB] reload after reset");
    fillPlus();
    applyStimulus(NBEATS, NBEATS - 1, 1'b0);
    for (int i = 0; i < NTAPS; i++) expCoef[i] = CW'(i + 1);
    expectCommit("reload");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
